sync_fifo_thresh: RTL and testbench
===================================

# sync_fifo_thresh

Parametrised synchronous FIFO with an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and support for non-power-of-two depths. It is the general-purpose buffering block between same-clock producers and consumers, replacing the fixed-function counted FIFO. Read timing is a compile-time choice: standard (registered) read or first-word-fall-through.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits (≥1)
- DATA_DEPTH, 8, number of storage words (≥2, any integer, power of two not required)
- AF_TH, DATA_DEPTH-1, almost_full asserts when fifo_cnt ≥ AF_TH (1..DATA_DEPTH)
- AE_TH, 1, almost_empty asserts when fifo_cnt ≤ AE_TH (0..DATA_DEPTH-1)

Ports (CW = $clog2(DATA_DEPTH+1)):
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request (acknowledge in FWFT mode)
- data_out  out  DATA_WIDTH  read data
- empty  out  1  fifo_cnt == 0
- full  out  1  fifo_cnt == DATA_DEPTH
- almost_full  out  1  fifo_cnt ≥ AF_TH
- almost_empty  out  1  fifo_cnt ≤ AE_TH
- fifo_cnt  out  CW  words currently stored
- overflow  out  1  sticky: write rejected since reset/clear
- underflow  out  1  sticky: read rejected since reset/clear
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Accept rules: wr_ok = wr_en & (!full | rd_ok); rd_ok = rd_en & !empty. A write when full is accepted only together with an accepted read.
- Rejected write (wr_en & !wr_ok): data dropped, storage/pointers unchanged, overflow set next edge.
- Rejected read (rd_en & empty): no pointer change, data_out holds, underflow set next edge. Applies also when wr_en is simultaneously asserted on empty: write accepted, read rejected.
- err_clr has priority over a same-cycle set: flags read 0 after the edge.
- Pointers wr_ptr/rd_ptr range 0..DATA_DEPTH-1; increment on accept, wrap DATA_DEPTH-1 → 0 (explicit compare, not bit truncation).
- fifo_cnt: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither. Never exceeds DATA_DEPTH nor goes below 0.
- empty, full, almost_full, almost_empty: combinational decodes of the registered fifo_cnt only (no dependence on current-cycle inputs).
- No state machine beyond counters/pointers; storage is not cleared on reset.

## Timing
- Reset (async assert, sync-safe deassert by system): fifo_cnt=0, pointers=0, data_out=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(AF_TH==0 ? 1 : 0) → always 0 given legal range.
- Reset mid-operation discards all contents; first accepted write after release is stored at address 0.
- Write latency: word written at edge N is readable (rd_ok possible) in cycle N+1; empty deasserts after edge N.
- Flags update one edge after the causing request.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. data_out = storage[rd_ptr] whenever !empty (valid in the same cycle empty is low); rd_en acknowledges the current word, next word appears after the edge. data_out is don't-care while empty.
- FIFO_FWFT_EN undefined: standard mode. On rd_ok at edge N, data_out registers storage[rd_ptr] and holds that value until the next rd_ok; read latency 1 cycle.
- Flag, count and error behaviour identical in both modes.

## Structure
- Package sync_fifo_pkg: cnt_width function ($clog2(depth+1)), pointer-wrap helper function, default parameter constants.
- One sub-module, sync_fifo_ram: DATA_DEPTH×DATA_WIDTH register array, one write port (synchronous), one asynchronous read port; output register for standard mode lives in sync_fifo_thresh.

## Test plan
Configuration DATA_WIDTH=8, DATA_DEPTH=6, AF_TH=5, AE_TH=1, both macro settings:
- Reset, then write 0x11..0x66 on 6 consecutive cycles -> fifo_cnt 1..6; almost_empty drops at cnt=2; almost_full rises at cnt=5; full at 6; overflow stays 0.
- 7th write 0x77 while full, rd_en=0 -> fifo_cnt stays 6, overflow=1; subsequent 6 reads return 0x11..0x66 in order (standard: one cycle after each rd_en), empty=1 after last.
- Read on empty -> underflow=1, data_out unchanged (standard) ; err_clr pulse -> underflow=0, overflow=0.
- Fill 4, then 20 cycles of simultaneous wr/rd with incrementing data -> fifo_cnt constant 4, output sequence strictly ordered across pointer wrap at address 5→0.
- Full plus simultaneous wr_en & rd_en -> both accepted, cnt stays 6, no overflow; empty plus both -> write accepted, cnt=1, underflow=1.
- Assert rst_n=0 asynchronously mid-burst with cnt=3 -> outputs at reset values immediately, before next clk edge; next write/read returns the new word only.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the thresholded synchronous FIFO:
// default parameter values, count-width sizing and pointer wrap helper.
// Optional feature macro used by sync_fifo_thresh: FIFO_FWFT_EN.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DATA_DEPTH = 8;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Next pointer value with an explicit wrap at depth-1, so depths that
    // are not a power of two wrap correctly.
    function automatic int unsigned ptr_next(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_thresh: DATA_DEPTH x DATA_WIDTH registers,
// one synchronous write port and one asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 8,
    parameter int AW         = 3
)(
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    // Write port: store the word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Parametrised synchronous FIFO with occupancy count, almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Depth need not be a power of two.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads;
// leave it undefined for a registered (one-cycle latency) read.
module sync_fifo_thresh
    import sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter  int AF_TH      = DATA_DEPTH - 1,
    parameter  int AE_TH      = 1,
    localparam int CW         = cnt_width(DATA_DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         fifo_cnt,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int            PW       = $clog2(DATA_DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] AF_TH_C  = CW'(AF_TH);
    localparam logic [CW-1:0] AE_TH_C  = CW'(AE_TH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  wr_ok;
    logic                  rd_ok;

    // Request/accept semantics: wr_en and rd_en are requests sampled on the
    // rising edge. A read is accepted whenever the FIFO holds a word; a write
    // is accepted when there is room, or when full but a read is accepted in
    // the same cycle (the freed slot is reused). Rejected requests have no
    // effect on storage, pointers or count and raise the matching sticky flag.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Status decodes look only at the registered count.
    assign empty        = (fifo_cnt == '0);
    assign full         = (fifo_cnt == DEPTH_C);
    assign almost_full  = (fifo_cnt >= AF_TH_C);
    assign almost_empty = (fifo_cnt <= AE_TH_C);

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Pointer advance on accepted transfers, wrapping at DATA_DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= PW'(ptr_next(32'(wr_ptr), DATA_DEPTH));
            end
            if (rd_ok) begin
                rd_ptr <= PW'(ptr_next(32'(rd_ptr), DATA_DEPTH));
            end
        end
    end

    // Occupancy count: moves only when exactly one side transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd_en acknowledges it.
    assign data_out = ram_rdata;
`else
    // Registered read: capture the head word on an accepted read and hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= ram_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh (DATA_WIDTH=8, DATA_DEPTH=6,
// AF_TH=5, AE_TH=1). Works with FIFO_FWFT_EN defined or undefined.
module tb_sync_fifo_thresh;

    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int CW    = 3;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard: words the FIFO should currently hold, oldest first.
    logic [DW-1:0] exp_q[$];
    logic          m_ov;
    logic          m_un;
    logic [DW-1:0] last_out;

    sync_fifo_thresh #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .AF_TH      (5),
        .AE_TH      (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_cnt     (fifo_cnt),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status outputs against the scoreboard occupancy and model flags.
    task automatic chk_status(input string tag);
        int sz;
        sz = exp_q.size();
        chk({tag, "_cnt"},   32'(fifo_cnt),     32'(sz));
        chk({tag, "_empty"}, 32'(empty),        32'(sz == 0));
        chk({tag, "_full"},  32'(full),         32'(sz == DEPTH));
        chk({tag, "_af"},    32'(almost_full),  32'(sz >= 5));
        chk({tag, "_ae"},    32'(almost_empty), 32'(sz <= 1));
        chk({tag, "_ov"},    32'(overflow),     32'(m_ov));
        chk({tag, "_un"},    32'(underflow),    32'(m_un));
    endtask

    // One clock of traffic; called and returns at a falling edge.
    task automatic cyc(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
        logic mw, mr;
        logic [DW-1:0] popped;
        popped  = '0;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        mr = r && (exp_q.size() > 0);
        mw = w && ((exp_q.size() < DEPTH) || mr);
`ifdef FIFO_FWFT_EN
        if (mr) chk({tag, "_fwft_data"}, 32'(data_out), 32'(exp_q[0]));
`endif
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (mr) popped = exp_q.pop_front();
        if (mw) exp_q.push_back(d);
        if (w && !mw) m_ov = 1'b1;
        if (r && !mr) m_un = 1'b1;
`ifndef FIFO_FWFT_EN
        if (mr) last_out = popped;
        chk({tag, "_data"}, 32'(data_out), 32'(last_out));
`endif
        chk_status(tag);
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
        chk("clr_ov", 32'(overflow), 32'd0);
        chk("clr_un", 32'(underflow), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = '0;
        err_clr  = 1'b0;
        m_ov     = 1'b0;
        m_un     = 1'b0;
        last_out = '0;

        // Reset values while reset is held
        #2;
        chk("rst_cnt",   32'(fifo_cnt),     32'd0);
        chk("rst_empty", 32'(empty),        32'd1);
        chk("rst_full",  32'(full),         32'd0);
        chk("rst_ae",    32'(almost_empty), 32'd1);
        chk("rst_af",    32'(almost_full),  32'd0);
        chk("rst_ov",    32'(overflow),     32'd0);
        chk("rst_un",    32'(underflow),    32'd0);
`ifndef FIFO_FWFT_EN
        chk("rst_dout",  32'(data_out),     32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x11..0x66, directed flag points
        cyc("w1", 1'b1, 8'h11, 1'b0);
        chk("w1_ae_hi", 32'(almost_empty), 32'd1);
        cyc("w2", 1'b1, 8'h22, 1'b0);
        chk("w2_ae_lo", 32'(almost_empty), 32'd0);
        cyc("w3", 1'b1, 8'h33, 1'b0);
        cyc("w4", 1'b1, 8'h44, 1'b0);
        chk("w4_af_lo", 32'(almost_full), 32'd0);
        cyc("w5", 1'b1, 8'h55, 1'b0);
        chk("w5_af_hi", 32'(almost_full), 32'd1);
        chk("w5_full",  32'(full), 32'd0);
        cyc("w6", 1'b1, 8'h66, 1'b0);
        chk("w6_cnt",  32'(fifo_cnt), 32'd6);
        chk("w6_full", 32'(full), 32'd1);
        chk("w6_ov",   32'(overflow), 32'd0);

        // Write while full is dropped
        cyc("w7", 1'b1, 8'h77, 1'b0);
        chk("w7_cnt", 32'(fifo_cnt), 32'd6);
        chk("w7_ov",  32'(overflow), 32'd1);

        // Drain in order
        for (int k = 1; k <= 6; k++) begin
            cyc("rd", 1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
            chk("rd_hand", 32'(data_out), 32'(8'h11 * k));
`endif
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Read on empty
        cyc("urd", 1'b0, 8'h00, 1'b1);
        chk("urd_un", 32'(underflow), 32'd1);
`ifndef FIFO_FWFT_EN
        chk("urd_hold", 32'(data_out), 32'h66);
`endif
        clr_err();

        // Fill 4 then streaming across pointer wrap
        for (int i = 0; i < 4; i++) cyc("f4", 1'b1, 8'(8'h20 + i), 1'b0);
        chk("f4_cnt", 32'(fifo_cnt), 32'd4);
        for (int i = 0; i < 20; i++) begin
            cyc("stream", 1'b1, 8'(8'h24 + i), 1'b1);
            chk("stream_cnt", 32'(fifo_cnt), 32'd4);
        end

        // Full with simultaneous write and read
        cyc("top5", 1'b1, 8'hA0, 1'b0);
        cyc("top6", 1'b1, 8'hA1, 1'b0);
        cyc("fullwr", 1'b1, 8'hA2, 1'b1);
        chk("fullwr_cnt", 32'(fifo_cnt), 32'd6);
        chk("fullwr_ov",  32'(overflow), 32'd0);
        for (int k = 0; k < 6; k++) cyc("drain2", 1'b0, 8'h00, 1'b1);

        // Empty with simultaneous write and read
        cyc("emptywr", 1'b1, 8'hEE, 1'b1);
        chk("emptywr_cnt", 32'(fifo_cnt), 32'd1);
        chk("emptywr_un",  32'(underflow), 32'd1);
        cyc("rdee", 1'b0, 8'h00, 1'b1);
        clr_err();

        // Asynchronous reset mid-burst
        cyc("b1", 1'b1, 8'h31, 1'b0);
        cyc("b2", 1'b1, 8'h32, 1'b0);
        cyc("b3", 1'b1, 8'h33, 1'b0);
        chk("b3_cnt", 32'(fifo_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",   32'(fifo_cnt), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ae",    32'(almost_empty), 32'd1);
`ifndef FIFO_FWFT_EN
        chk("arst_dout",  32'(data_out), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_ov     = 1'b0;
        m_un     = 1'b0;
        last_out = '0;
        cyc("pw", 1'b1, 8'hA5, 1'b0);
        cyc("pr", 1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("pr_hand", 32'(data_out), 32'hA5);
`endif
        chk("pr_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
